perceptron_trainer: RTL and testbench
=====================================

Name: perceptron_trainer

Overview:
- Sequential training engine for one 8-input binary-input perceptron of the network layer.
- Runs the learning direction: forward sum, then the perceptron learning rule writes updated weights and threshold back.
- Evaluates one input bit per cycle, so a single adder is time-shared across all 8 inputs.
- Trained weights are read back through a register port and can be used as the fixed constants of the inference layer.

Parameters:
- W, 8, signed weight/threshold width (two's complement).
- LR, 1, learning-rate step added/subtracted per update (positive, < 2^(W-1)).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin one sample; sampled only in IDLE
- train  input  1  1 = train after evaluating, 0 = evaluate only; captured with start
- x_in  input  8  binary input vector, bit i multiplies weight i; captured with start
- target  input  1  desired output; captured with start
- wr_en  input  1  register write strobe; honoured only in IDLE
- wr_addr  input  4  0..7 = weight i, 8 = threshold, 9..15 ignored
- wr_data  input  W  signed write data
- rd_addr  input  4  readback address, same map; 9..15 read 0
- rd_data  output  W  combinational readback of the addressed register
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at completion
- y_out  output  1  perceptron output of the last sample; held until the next completion
- err  output  1  y_out != target of the last sample (also valid in evaluate mode); held

Behaviour:
- Reset (asynchronous, rst_n low): all weights = 0, threshold = 0, state IDLE; busy, done, y_out, err = 0; accumulator and index = 0.
- FSM states: IDLE, ACCUM, COMPARE, UPDATE, DONE.
- IDLE:
  - When start = 1, capture x_in, target and train; clear the accumulator and set index = 0; go to ACCUM.
  - If start and wr_en are both high in the same cycle, the write occurs and start is still accepted. The captured sample sees the post-write register value.
- ACCUM: 8 cycles, index 0..7. Each cycle, acc += sign-extended w[index] if x[index] = 1.
  - acc is W+4 bits signed, so it cannot overflow.
- COMPARE: 1 cycle.
  - y = (acc > sign-extended threshold), strictly greater.
  - err_next = (y != target).
  - If train = 1 and err_next = 1, go to UPDATE with index = 0; otherwise go to DONE.
- UPDATE: 8 cycles, index 0..7.
  - delta = +LR if target = 1, -LR if target = 0.
  - If x[index] = 1, w[index] = sat(w[index] + delta).
  - On the last cycle, also threshold = sat(threshold - delta).
  - sat clamps to [-2^(W-1), 2^(W-1)-1].
- DONE: 1 cycle. done = 1; y_out and err take their new values; busy = 0 in this cycle; return to IDLE.
- Latency, counting from the start-sampling edge:
  - done is high in cycle +10 with no update, or +18 with update.
  - busy is high in cycles +1..+9 or +1..+17.
- Error-free sample in train mode: no update, and weights are unchanged.
- start while busy: ignored, not queued.
- wr_en while busy: ignored; registers are unchanged.
- rd_data is valid in any state. During UPDATE it shows the live, partially updated value.
- Reset mid-operation: immediate return to reset values. Any partial weight updates are discarded, since weights are reset to 0 as well.

Decomposition:
- Shared package holds:
  - the address map constants (ADDR_THETA = 8, NUM_IN = 8);
  - the FSM state enumeration;
  - the W+4 accumulator width constant.
- One natural sub-module: sat_add, a signed W-bit saturating adder. It is used for both weight and threshold updates.
- The FSM, register file and accumulator stay in perceptron_trainer.

Test Plan:
- Reset: assert rst_n low mid-sim -> rd_data = 0 for all addresses 0..8; busy, done, y_out, err all 0.
- Evaluate:
  - Write w0..w7 = 1,2,3,4,2,2,2,1, threshold = 10.
  - start with x_in = 0x0F, train = 0, target = 1.
  - Expected: sum = 10, so y_out = 0, err = 1; done at +10; weights unchanged.
- Train: same setup with train = 1.
  - Expected: done at +18; w0..w3 = 2,3,4,5; w4..w7 unchanged; threshold = 9.
  - Repeat the evaluate -> sum 14 > 9, y_out = 1, err = 0, done at +10.
- Saturation:
  - Write w0 = 127, threshold = 127; start with x_in = 0x01, target = 1, train = 1.
  - Expected: y_out = 0; w0 stays 127; threshold = 126.
  - Then write w1 = -128; start with x_in = 0x02, target = 0, train = 1, threshold = -128.
  - Expected: sum -128 is not > -128, so y_out = 0 = target and no update occurs.
- Busy protection:
  - During ACCUM, pulse start and wr_en (addr 0, data 55).
  - Expected: only one done pulse; w0 unchanged; done cycle count unaffected.
- Reset mid-UPDATE: drop rst_n at cycle +13 of a training sample.
  - Expected: all registers read 0; no done pulse.
  - A new start afterwards completes normally at +10 or +18.

Source files
------------

// File: rtl/perceptron_trainer_pkg.sv
// Shared constants, FSM encoding and sample payload for the perceptron trainer.
package perceptron_trainer_pkg;

    localparam int unsigned NUM_IN     = 8;
    localparam int unsigned ADDR_THETA = 8;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned ACC_GUARD  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_COMPARE,
        ST_UPDATE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              train;
        logic              target;
        logic [NUM_IN-1:0] x;
    } sample_t;

    // Eight W-bit terms need 3 guard bits; one extra keeps the sign clear.
    function automatic int unsigned acc_width(input int unsigned w);
        return w + ACC_GUARD;
    endfunction

endpackage

// File: rtl/perceptron_trainer_sat_add.sv
// Signed W-bit adder that clamps to the representable range instead of wrapping.
module perceptron_trainer_sat_add #(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum_c
);

    logic signed [W:0] w_sum;

    assign w_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};

    // Overflow shows as disagreement between the guard bit and the W-bit sign.
    always_comb begin
        o_sum_c = w_sum[W-1:0];
        if (w_sum[W] != w_sum[W-1]) begin
            o_sum_c = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Bit-serial perceptron: accumulates one input per cycle, thresholds, and applies
// the perceptron learning rule to the weights and threshold when training.
module perceptron_trainer
    import perceptron_trainer_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned LR = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                train,
    input  logic [NUM_IN-1:0]   x_in,
    input  logic                target,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic signed [W-1:0] wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic signed [W-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic                y_out,
    output logic                err
);

    localparam int unsigned ACC_W = acc_width(W);

    state_t                  r_state;
    state_t                  w_next;
    logic signed [W-1:0]     r_w [NUM_IN];
    logic signed [W-1:0]     r_theta;
    logic signed [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0]        r_idx;
    sample_t                 r_smp;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_y;
    logic                    r_err;
    logic                    r_y_pend;
    logic                    r_err_pend;

    logic signed [W-1:0]     w_wsel;
    logic signed [ACC_W-1:0] w_wsel_ext;
    logic signed [ACC_W-1:0] w_theta_ext;
    logic signed [W-1:0]     w_lr;
    logic signed [W-1:0]     w_delta;
    logic signed [W-1:0]     w_ndelta;
    logic signed [W-1:0]     w_w_sat;
    logic signed [W-1:0]     w_theta_sat;
    logic                    w_last;
    logic                    w_y;
    logic                    w_err;

    assign w_wsel      = r_w[r_idx];
    assign w_wsel_ext  = {{(ACC_W-W){w_wsel[W-1]}}, w_wsel};
    assign w_theta_ext = {{(ACC_W-W){r_theta[W-1]}}, r_theta};
    assign w_lr        = W'(LR);
    assign w_delta     = r_smp.target ? w_lr : -w_lr;
    assign w_ndelta    = r_smp.target ? -w_lr : w_lr;
    assign w_last      = (r_idx == IDX_W'(NUM_IN - 1));
    assign w_y         = (r_acc > w_theta_ext);
    assign w_err       = (w_y != r_smp.target);

    perceptron_trainer_sat_add #(.W(W)) u_sat_w (
        .i_a     (w_wsel),
        .i_b     (w_delta),
        .o_sum_c (w_w_sat)
    );

    perceptron_trainer_sat_add #(.W(W)) u_sat_theta (
        .i_a     (r_theta),
        .i_b     (w_ndelta),
        .o_sum_c (w_theta_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_ACCUM;
            ST_ACCUM:   if (w_last) w_next = ST_COMPARE;
            ST_COMPARE: w_next = (r_smp.train && w_err) ? ST_UPDATE : ST_DONE;
            ST_UPDATE:  if (w_last) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_y    <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (w_next inside {ST_ACCUM, ST_COMPARE, ST_UPDATE});
            r_done <= (w_next == ST_DONE);
            if (w_next == ST_DONE) begin
                r_y   <= (r_state == ST_COMPARE) ? w_y : r_y_pend;
                r_err <= (r_state == ST_COMPARE) ? w_err : r_err_pend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                r_w[i] <= '0;
            end
            r_theta    <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_smp      <= '0;
            r_y_pend   <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wr_en) begin
                        if (wr_addr < ADDR_W'(ADDR_THETA)) begin
                            r_w[wr_addr[IDX_W-1:0]] <= wr_data;
                        end else if (wr_addr == ADDR_W'(ADDR_THETA)) begin
                            r_theta <= wr_data;
                        end
                    end
                    if (start) begin
                        r_smp <= '{train: train, target: target, x: x_in};
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (r_smp.x[r_idx]) begin
                        r_acc <= r_acc + w_wsel_ext;
                    end
                    r_idx <= r_idx + IDX_W'(1);
                end
                ST_COMPARE: begin
                    r_y_pend   <= w_y;
                    r_err_pend <= w_err;
                    r_idx      <= '0;
                end
                ST_UPDATE: begin
                    if (r_smp.x[r_idx]) begin
                        r_w[r_idx] <= w_w_sat;
                    end
                    if (w_last) begin
                        r_theta <= w_theta_sat;
                    end
                    r_idx <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < ADDR_W'(ADDR_THETA)) begin
            rd_data = r_w[rd_addr[IDX_W-1:0]];
        end else if (rd_addr == ADDR_W'(ADDR_THETA)) begin
            rd_data = r_theta;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign y_out = r_y;
    assign err   = r_err;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with a behavioural register model and
// an expected-result queue checked at each done pulse.
module tb_perceptron_trainer;

    localparam int W  = 8;
    localparam int LR = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              train;
    logic [7:0]        x_in;
    logic              target;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic signed [7:0] wr_data;
    logic [3:0]        rd_addr;
    logic signed [7:0] rd_data;
    logic              busy;
    logic              done;
    logic              y_out;
    logic              err;

    typedef struct {
        int y;
        int e;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   m_w[9];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    perceptron_trainer #(.W(W), .LR(LR)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .train   (train),
        .x_in    (x_in),
        .target  (target),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .y_out   (y_out),
        .err     (err)
    );

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic do_write(input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
        if (a <= 8) m_w[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a <= 9; a++) begin
            rd_addr = 4'(a);
            #1;
            check($sformatf("%s_rd%0d", tag, a), int'(rd_data), (a <= 8) ? m_w[a] : 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input int ey, input int ee);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_y"}, int'(y_out), ey);
        check({tag, "_err"}, int'(err), ee);
    endtask

    // poke_at: cycle to pulse start+wr_en while busy; rst_at: cycle to assert reset.
    task automatic run_sample(input string tag, input logic [7:0] x, input int tgt,
                              input int trn, input int poke_at, input int rst_at);
        exp_t e;
        exp_t got;
        int   s;
        int   d;
        int   lat;
        int   busy_ok;
        int   aborted;
        s = 0;
        for (int i = 0; i < 8; i++) if (x[i]) s += m_w[i];
        e.y   = (s > m_w[8]) ? 1 : 0;
        e.e   = (e.y != tgt) ? 1 : 0;
        e.lat = (trn != 0 && e.e != 0) ? 18 : 10;
        if (trn != 0 && e.e != 0) begin
            d = (tgt != 0) ? LR : -LR;
            for (int i = 0; i < 8; i++) if (x[i]) m_w[i] = sat8(m_w[i] + d);
            m_w[8] = sat8(m_w[8] - d);
        end
        exp_q.push_back(e);

        @(negedge clk);
        start  = 1'b1;
        x_in   = x;
        target = tgt[0];
        train  = trn[0];
        @(negedge clk);
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1;
        aborted = 0;
        while (done !== 1'b1 && lat < 40 && aborted == 0) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (lat == poke_at) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 4'd0;
                wr_data = 8'sd55;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (lat == rst_at) begin
                rst_n   = 1'b0;
                aborted = 1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        got   = exp_q.pop_front();

        if (aborted != 0) begin
            for (int i = 0; i < 9; i++) m_w[i] = 0;
            #1;
            check_idle_outputs({tag, "_rst"}, 0, 0);
            check_regs({tag, "_rst"});
            d = 0;
            repeat (20) begin
                @(negedge clk);
                if (done === 1'b1) d++;
            end
            check({tag, "_no_done"}, d, 0);
            rst_n = 1'b1;
        end else begin
            check({tag, "_lat"}, lat, got.lat);
            check({tag, "_y"}, int'(y_out), got.y);
            check({tag, "_err"}, int'(err), got.e);
            check({tag, "_busy_done"}, int'(busy), 0);
            check({tag, "_busy_span"}, busy_ok, 1);
            @(negedge clk);
            check({tag, "_done_pulse"}, int'(done), 0);
        end
    endtask

    initial begin
        int extra;
        rst_n   = 1'b0;
        start   = 1'b0;
        train   = 1'b0;
        x_in    = '0;
        target  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        for (int i = 0; i < 9; i++) m_w[i] = 0;

        repeat (3) @(negedge clk);
        check_idle_outputs("por", 0, 0);
        check_regs("por");
        rst_n = 1'b1;

        // Load, then reset mid-simulation and confirm everything clears.
        do_write(0, 33); do_write(5, -7); do_write(8, 12);
        check_regs("wr");
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 9; i++) m_w[i] = 0;
        #1;
        check_idle_outputs("rst", 0, 0);
        check_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        do_write(0, 1); do_write(1, 2); do_write(2, 3); do_write(3, 4);
        do_write(4, 2); do_write(5, 2); do_write(6, 2); do_write(7, 1);
        do_write(8, 10);
        do_write(12, 99);
        check_regs("setup");

        run_sample("eval", 8'h0F, 1, 0, -1, -1);
        check_regs("eval");

        run_sample("train", 8'h0F, 1, 1, -1, -1);
        rd_addr = 4'd3; #1;
        check("train_w3", int'(rd_data), 5);
        rd_addr = 4'd8; #1;
        check("train_theta", int'(rd_data), 9);
        check_regs("train");

        run_sample("reeval", 8'h0F, 1, 0, -1, -1);
        check("reeval_y_const", int'(y_out), 1);

        do_write(0, 127); do_write(8, 127);
        run_sample("sat_hi", 8'h01, 1, 1, -1, -1);
        check_regs("sat_hi");

        do_write(1, -128); do_write(8, -128);
        run_sample("sat_lo", 8'h02, 0, 1, -1, -1);
        check_regs("sat_lo");

        run_sample("busy", 8'h0F, 1, 0, 3, -1);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("busy_extra_done", extra, 0);
        check_regs("busy");

        run_sample("abort", 8'h04, 0, 1, -1, 13);
        run_sample("after", 8'h01, 1, 1, -1, -1);
        check_regs("after");

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
